// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor.
//
// Both operands are captured on an accepted start pulse. They are then processed
// LSB first, one bit per clock, through a single full-adder cell and a carry
// flip-flop. The WIDTH-bit result and the carry/borrow flag are published
// together with a one-cycle done pulse.
//
// Configuration macro:
//   SERIAL_ADDSUB_SUB_EN  defined   -> sub selects A-B, computed as A + ~B + 1.
//                         undefined -> no subtract hardware is built. sub is
//                                      ignored and every operation is A+B.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   start      operation request, sampled only while idle
//   op_a       operand A (addend / minuend), captured on accepted start
//   op_b       operand B (addend / subtrahend), captured on accepted start
//   sub        0 = A+B, 1 = A-B, captured on accepted start
//   busy       high while bits are being processed
//   done       one-cycle pulse in the cycle result/carry_out first show a new value
//   result     last completed result, held until the next done
//   carry_out  add: carry out of the MSB; subtract: borrow (A < B unsigned)

module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    // Must hold the value WIDTH without wrapping within one operation.
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] sh_r_q, sh_r_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             cin_q, cin_d;
    logic             carry_q, carry_d;

    // Full-adder cell signals.
    logic             a_bit;
    logic             b_bit;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] sh_r_next;
    logic             last_bit;

`ifdef SERIAL_ADDSUB_SUB_EN
    logic mode_q, mode_d;
`else
    // sub has no function in an add-only build.
    logic unused_sub;
    assign unused_sub = sub;
`endif

    // ------------------------------------------------------------------
    // Bit-serial datapath
    // ------------------------------------------------------------------
    assign a_bit = sh_a_q[0];

`ifdef SERIAL_ADDSUB_SUB_EN
    // Subtraction inverts B; the +1 comes from presetting cin on start.
    assign b_bit = sh_b_q[0] ^ mode_q;
`else
    assign b_bit = sh_b_q[0];
`endif

    assign s_bit     = a_bit ^ b_bit ^ cin_q;
    assign c_next    = (a_bit & b_bit) | (a_bit & cin_q) | (b_bit & cin_q);
    assign sh_r_next = {s_bit, sh_r_q[WIDTH-1:1]};
    assign last_bit  = (cnt_q == CntW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        sh_r_d   = sh_r_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        cin_d    = cin_q;
        carry_d  = carry_q;
`ifdef SERIAL_ADDSUB_SUB_EN
        mode_d   = mode_q;
`endif
        busy     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sh_a_d  = op_a;
                    sh_b_d  = op_b;
                    sh_r_d  = '0;
                    cnt_d   = '0;
`ifdef SERIAL_ADDSUB_SUB_EN
                    mode_d  = sub;
                    cin_d   = sub;
`else
                    cin_d   = 1'b0;
`endif
                    state_d = StRun;
                end
            end

            StRun: begin
                busy   = 1'b1;
                cin_d  = c_next;
                sh_r_d = sh_r_next;
                sh_a_d = sh_a_q >> 1;
                sh_b_d = sh_b_q >> 1;
                cnt_d  = cnt_q + CntW'(1);
                if (last_bit) begin
                    // Publish on the edge entering StDone, so the new value and
                    // the done pulse appear in the same cycle. Partial shift
                    // contents never reach the output.
                    result_d = sh_r_next;
`ifdef SERIAL_ADDSUB_SUB_EN
                    // For A + ~B + 1 a missing carry means a borrow.
                    carry_d  = mode_q ? ~c_next : c_next;
`else
                    carry_d  = c_next;
`endif
                    state_d  = StDone;
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers (synchronous reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sh_r_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            cin_q    <= 1'b0;
            carry_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_SUB_EN
            mode_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            sh_r_q   <= sh_r_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            cin_q    <= cin_d;
            carry_q  <= carry_d;
`ifdef SERIAL_ADDSUB_SUB_EN
            mode_q   <= mode_d;
`endif
        end
    end

    assign result    = result_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8). Expected results are pushed
// to a queue when an operation is issued. A monitor pops and compares them when
// done pulses.
module tb_serial_addsub;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             c;
        int               due;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   done_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s, input int due);
        exp_t e;
        logic eff_sub;
`ifdef SERIAL_ADDSUB_SUB_EN
        eff_sub = s;
`else
        eff_sub = 1'b0;
`endif
        if (eff_sub) begin
            e.res = a - b;
            e.c   = (a < b);
        end else begin
            {e.c, e.res} = {1'b0, a} + {1'b0, b};
        end
        e.due = due;
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest issued operation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("result", 32'(result), 32'(e.res));
                check_eq("carry_out", 32'(carry_out), 32'(e.c));
                check_eq("done_cycle", cyc, e.due);
            end
        end
    end

    // Called just after a negedge; drives start for one cycle and scrambles the
    // operands afterwards, which must not affect the accepted operation.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        sub   = s;
        exp_q.push_back(model(a, b, s, cyc + WIDTH + 1));
        @(negedge clk);
        start = 1'b0;
        op_a  = 8'($urandom);
        op_b  = 8'($urandom);
        sub   = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            check_eq("timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int busy_cycles;
        int dc_snap;
        logic [WIDTH-1:0] ra, rb;
        logic             rs;

        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        sub   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_carry", 32'(carry_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic add with busy-window and done-pulse timing.
        issue(8'h35, 8'h4A, 1'b0);
        busy_cycles = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (busy === 1'b1) busy_cycles++;
            if (i < WIDTH) @(negedge clk);
        end
        check_eq("busy_cycles", busy_cycles, WIDTH);
        check_eq("busy_in_done", 32'(busy), 32'd0);
        check_eq("done_pulse", 32'(done), 32'd1);
        wait_idle();
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("result_held", 32'(result), 32'h7F);

        // Add with overflow, exactly one done.
        dc_snap = done_count;
        issue(8'hFF, 8'h01, 1'b0);
        wait_idle();
        repeat (4) @(negedge clk);
        check_eq("overflow_done_count", done_count - dc_snap, 1);

`ifdef SERIAL_ADDSUB_SUB_EN
        issue(8'h10, 8'h01, 1'b1);
        wait_idle();
        issue(8'h00, 8'h01, 1'b1);
        wait_idle();
`else
        // sub is ignored: 0x10 + 0x01.
        issue(8'h10, 8'h01, 1'b1);
        wait_idle();
`endif

        // Starts during RUN and DONE are ignored; start in cycle 11 is accepted.
        dc_snap = done_count;
        issue(8'h01, 8'h01, 1'b0);               // cycle 0; now in cycle 1
        repeat (3) @(negedge clk);               // cycle 4
        start = 1'b1; op_a = 8'hAA; op_b = 8'h11; sub = 1'b0;
        @(negedge clk);                          // cycle 5
        start = 1'b0;
        repeat (4) @(negedge clk);               // cycle 9 (DONE)
        start = 1'b1; op_a = 8'hAA; op_b = 8'h11;
        @(negedge clk);                          // cycle 10
        start = 1'b0;
        check_eq("reject_done_count", done_count - dc_snap, 1);
        check_eq("reject_result", 32'(result), 32'h02);
        @(negedge clk);                          // cycle 11
        issue(8'h20, 8'h03, 1'b0);
        wait_idle();

        // Reset mid-run: abort without done, outputs cleared.
        issue(8'h35, 8'h4A, 1'b0);               // cycle 0; now in cycle 1
        repeat (4) @(negedge clk);               // cycle 5
        rst = 1'b1;
        @(negedge clk);                          // cycle 6
        exp_q.delete();
        dc_snap = done_count;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_result", 32'(result), 32'd0);
        check_eq("abort_carry", 32'(carry_out), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("abort_no_done", done_count - dc_snap, 0);
        issue(8'h35, 8'h4A, 1'b0);
        wait_idle();

        // Random operations.
        for (int k = 0; k < 8; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            issue(ra, rb, rs);
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial adder/subtractor for the TinyTapeout datapath: the sequential counterpart of the existing combinational sum/carry logic. It accepts two WIDTH-bit operands on a start pulse and processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It returns the WIDTH-bit result with a carry (add) or borrow (subtract) flag and a one-cycle done pulse. It sits between the ui_in/uio_in operand capture logic and the uo_out drive logic.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE
- op_a  input  WIDTH  minuend/addend A, captured on accepted start
- op_b  input  WIDTH  subtrahend/addend B, captured on accepted start
- sub  input  1  0 = A+B, 1 = A−B; captured on accepted start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  single-cycle pulse when result/carry_out update
- result  output  WIDTH  last completed result, held until next done
- carry_out  output  1  add: carry out of MSB; sub: borrow (1 when A<B unsigned)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → latch op_a→shA, op_b→shB, sub→mode; cnt←0; cin←mode; → RUN.
- RUN, one bit per cycle:
  - b = shB[0] ^ mode
  - s = shA[0] ^ b ^ cin
  - cin ← majority(shA[0], b, cin)
  - shR ← {s, shR[WIDTH-1:1]}; shA, shB shift right by 1
  - cnt ← cnt+1
  - after WIDTH bits → DONE
- DONE: result ← shR; carry_out ← mode ? ~cin : cin; done=1; → IDLE.
- Arithmetic is modulo 2^WIDTH; subtract is A + ~B + 1.
- start in RUN or DONE is ignored; no queuing.
- Changes on op_a/op_b/sub after acceptance have no effect.
- result/carry_out change only in the DONE cycle; they never expose partial shR contents.

## Timing
- Reset values: busy=0, done=0, result=0, carry_out=0, state=IDLE, cnt=0, cin=0.
- Start sampled high at the edge ending cycle 0 → busy=1 in cycles 1..WIDTH; done=1 and new result/carry_out visible in cycle WIDTH+1; busy=0 in cycle WIDTH+1.
- Latency start→done: WIDTH+1 cycles. Earliest next accepted start: sampled in cycle WIDTH+2 (throughput one op per WIDTH+2 cycles).
- rst=1 has priority over start at the same edge.
- rst=1 mid-RUN aborts with no done pulse; result/carry_out return to 0.
- cnt is ⌈log2(WIDTH+1)⌉ bits; no wrap within one operation.

## Configuration
- SERIAL_ADDSUB_SUB_EN defined: behaviour as above; sub selects subtraction.
- Undefined: the subtract path (B inversion, cin preset, borrow inversion) is not built. sub is ignored, mode is treated as 0, and every operation is an add with carry_out = true carry.

## Test plan
- Add, WIDTH=8: A=0x35, B=0x4A, sub=0, start in cycle 0 → busy cycles 1–8, done cycle 9, result=0x7F, carry_out=0.
- Add overflow: A=0xFF, B=0x01 → result=0x00, carry_out=1, done exactly once.
- Subtract (macro on): A=0x10, B=0x01, sub=1 → result=0x0F, carry_out=0. A=0x00, B=0x01 → result=0xFF, carry_out=1.
- Busy rejection: start A=0x01+0x01; pulse start with A=0xAA, B=0x11 in cycle 4 and again in the DONE cycle → single done, result=0x02; next start in cycle 11 accepted.
- Reset mid-run: start A=0x35, B=0x4A; rst=1 in cycle 5 → busy=0, no done, result=0x00 and carry_out=0 next cycle. A new start after rst deasserts completes normally.
- Macro off: A=0x10, B=0x01, sub=1 → result=0x11, carry_out=0.
